serial_to_parallel_rx: RTL and testbench
========================================

// Module: serial_to_parallel_rx
// PURPOSE
//  Receive end of the parallel-to-serial link. Samples the serial bitstream on s_clk and
//  reassembles it into WIDTH-bit words. Completed words are buffered in a DEPTH-entry
//  synchronous FIFO and presented on a valid/ready parallel port. Upstream flow control
//  is a grant back to the serializer; overflow is reported on a sticky overrun flag.
// PARAMETERS
//  WIDTH      32  bits per word (>=2)
//  DEPTH      4   output FIFO entries (power of two, >=2)
//  MSB_FIRST  1   1: first received bit lands in bit WIDTH-1; 0: first bit lands in bit 0
// PORTS
//  s_clk              in   1                 serial clock; only clock, all logic on posedge
//  rst                in   1                 synchronous, active-high reset
//  flush              in   1                 sync clear of word assembly, FIFO and overrun
//  serial_in          in   1                 serial data bit
//  serial_valid       in   1                 serial_in carries a valid bit this cycle
//  grant              out  1                 receiver can accept bits (= !full)
//  parallel_data_out  out  WIDTH             head-of-FIFO word (FWFT, combinational from mem)
//  out_valid          out  1                 parallel_data_out valid (= !empty)
//  out_ready          in   1                 consumer accepts word when out_valid&out_ready
//  full               out  1                 FIFO holds DEPTH words
//  empty              out  1                 FIFO holds 0 words
//  overrun            out  1                 sticky: a completed word was dropped
//  bit_count          out  $clog2(WIDTH)     bits of current word received so far
// BEHAVIOUR
//  - Priority per edge: rst > flush > normal operation.
//  - Reset/flush values: bit_count=0, shift reg=0, FIFO ptrs=0, empty=1, full=0,
//    out_valid=0, grant=1, overrun=0, FSM=IDLE. parallel_data_out is don't-care while empty.
//  - FSM: IDLE (bit_count==0) -> SHIFT on serial_valid. SHIFT stays while bit_count<WIDTH-1;
//    the edge sampling bit WIDTH-1 performs the push and returns to IDLE, bit_count=0.
//    serial_valid=0 in any state: hold shift reg and bit_count (stall, no timeout).
//  - Shift: MSB_FIRST=1 -> sr <= {sr[WIDTH-2:0], serial_in}; else sr <= {serial_in, sr[WIDTH-1:1]}.
//  - Push: word written is the shift contents including the bit sampled that same edge.
//    Latency: out_valid rises the cycle after the edge sampling the last bit (into empty FIFO).
//  - Pop: on out_valid&out_ready at an edge; rd_ptr advances; next word visible same cycle.
//  - Pointers are $clog2(DEPTH)+1 bits with wrap bit; full = addr equal & wrap differ;
//    empty = pointers equal. Wrap-around at DEPTH is seamless.
//  - Push while full with no pop same edge: word dropped, FIFO unchanged, overrun<=1,
//    assembly restarts at IDLE. Push while full WITH pop same edge: both happen, no overrun.
//  - Pop while empty: ignored. Push and pop same edge when not full: count unchanged.
//  - grant is advisory; bits sent while grant=0 are still shifted (upstream must honour it).
//  - flush mid-word discards partial bits; flush wins over a coincident push/pop.
//  - overrun clears only on rst or flush.
// TESTING
//  1 Reset: assert rst 3 cycles with serial_valid=1 -> bit_count=0, empty=1, full=0,
//    out_valid=0, grant=1, overrun=0; no word pushed.
//  2 Single word: shift 32'h11111111 MSB-first, out_ready=0 -> out_valid=1 one cycle after
//    bit 31, parallel_data_out=32'h11111111, empty=0; out_ready=1 one cycle -> empty=1.
//  3 Stalls: send 32'hFFFF0000 with serial_valid low for 3 cycles after bits 5 and 20
//    -> bit_count holds during gaps; word received exactly 32'hFFFF0000.
//  4 Overflow: out_ready=0, send 4 words 32'hA0000001..32'hA0000004 -> full=1, grant=0;
//    5th word 32'hDEADBEEF -> overrun=1, dropped; drain yields A0000001..A0000004 in order.
//  5 Flush mid-word: 10 bits sent, flush=1 one cycle with 2 words buffered -> bit_count=0,
//    empty=1, overrun=0; next 32 bits 32'h12345678 -> clean word 32'h12345678.
//  6 Full + simultaneous pop/push: FIFO full, last bit of 32'hCAFEF00D on the edge with
//    out_ready=1 -> overrun stays 0, full stays 1, CAFEF00D read out last after draining.

Source files
------------

// File: rtl/serial_to_parallel_rx.sv
// ---------------------------------------------------------------------------
// serial_to_parallel_rx
//
// Receive end of the parallel-to-serial link. Bits arriving on serial_in
// (qualified by serial_valid) are shifted into a WIDTH-bit assembly register.
// When the last bit of a word is sampled, the finished word is pushed into a
// DEPTH-entry first-word-fall-through FIFO. The FIFO head is presented on a
// valid/ready parallel port.
//
// Ports
//   s_clk             in   1        only clock, everything on posedge
//   rst               in   1        synchronous active-high reset
//   flush             in   1        synchronous clear of assembly, FIFO, overrun
//   serial_in         in   1        serial data bit
//   serial_valid      in   1        serial_in carries a bit this cycle
//   grant             out  1        receiver can accept bits (not full)
//   parallel_data_out out  WIDTH    head-of-FIFO word, combinational from memory
//   out_valid         out  1        parallel_data_out holds a word (not empty)
//   out_ready         in   1        consumer takes the head word
//   full              out  1        FIFO holds DEPTH words
//   empty             out  1        FIFO holds no words
//   overrun           out  1        sticky: a completed word was dropped
//   bit_count         out  clog2(W) bits of the current word received so far
// ---------------------------------------------------------------------------
module serial_to_parallel_rx #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       s_clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       serial_in,
  input  logic                       serial_valid,
  output logic                       grant,
  output logic [WIDTH-1:0]           parallel_data_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       full,
  output logic                       empty,
  output logic                       overrun,
  output logic [$clog2(WIDTH)-1:0]   bit_count
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;

  logic [CW-1:0]     r_bitCount;
  logic [WIDTH-1:0]  r_shift;
  logic [WIDTH-1:0]  w_shiftNext;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PW-1:0]     r_wrPtr;
  logic [PW-1:0]     r_rdPtr;
  logic              r_overrun;

  logic              w_shiftEn;
  logic              w_lastBit;
  logic              w_wordDone;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_wrEn;
  logic              w_drop;

  // The word is complete when the bit being sampled this edge is the
  // WIDTH-th one, i.e. the counter already shows WIDTH-1 bits received.
  assign w_lastBit = (r_bitCount == CW'(WIDTH - 1));

  // The shift direction decides where the first received bit ends up.
  // This is also the value that gets pushed on the final bit, so the
  // pushed word already includes the bit sampled on that same edge.
  always_comb begin
    w_shiftNext = r_shift;
    if (MSB_FIRST) begin
      w_shiftNext = {r_shift[WIDTH-2:0], serial_in};
    end else begin
      w_shiftNext = {serial_in, r_shift[WIDTH-1:1]};
    end
  end

  // FSM state register: reset and flush both return to IDLE.
  always_ff @(posedge s_clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (flush) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // FSM next-state logic: a valid bit in IDLE starts a word, the final bit
  // of a word returns to IDLE. With serial_valid low the state just holds,
  // so an upstream pause of any length is tolerated.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: begin
        if (serial_valid) begin
          w_stateNext = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (serial_valid && w_lastBit) begin
          w_stateNext = ST_IDLE;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: every valid bit is shifted regardless of grant (grant is
  // only advisory), and the word is finished only by the final bit while
  // in SHIFT. Because WIDTH is at least 2 the final bit never arrives in IDLE.
  always_comb begin
    w_shiftEn  = 1'b0;
    w_wordDone = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_shiftEn = serial_valid;
      end
      ST_SHIFT: begin
        w_shiftEn  = serial_valid;
        w_wordDone = serial_valid && w_lastBit;
      end
      default: begin
        w_shiftEn  = 1'b0;
        w_wordDone = 1'b0;
      end
    endcase
  end

  // Bit counter and assembly register. The counter wraps to zero on the
  // final bit whether or not the FIFO could take the word, so a dropped
  // word never leaves assembly out of step with the bitstream.
  always_ff @(posedge s_clk) begin
    if (rst) begin
      r_bitCount <= '0;
      r_shift    <= '0;
    end else if (flush) begin
      r_bitCount <= '0;
      r_shift    <= '0;
    end else if (w_shiftEn) begin
      r_shift <= w_shiftNext;
      if (w_lastBit) begin
        r_bitCount <= '0;
      end else begin
        r_bitCount <= r_bitCount + CW'(1);
      end
    end
  end

  // FIFO status uses an extra wrap bit on each pointer: equal addresses
  // with differing wrap bits mean full, identical pointers mean empty.
  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]) &&
                   (r_wrPtr[AW] != r_rdPtr[AW]);

  // A pop while full frees the slot the incoming word needs, so a push
  // coinciding with a pop is always accepted. Only a push into a full FIFO
  // with no pop is dropped.
  assign w_pop  = !w_empty && out_ready;
  assign w_wrEn = w_wordDone && (!w_full || w_pop);
  assign w_drop = w_wordDone && w_full && !w_pop;

  // FIFO storage has no reset; entries are only ever read once the write
  // pointer has moved past them. Writes are suppressed during reset and
  // flush so a clear really discards the word completing on that edge.
  always_ff @(posedge s_clk) begin
    if (!rst && !flush && w_wrEn) begin
      r_mem[r_wrPtr[AW-1:0]] <= w_shiftNext;
    end
  end

  // Pointer update: flush wins over any coincident push or pop.
  always_ff @(posedge s_clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_wrEn) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
    end
  end

  // Overrun is sticky: once a word has been lost it stays set until the
  // link is reset or flushed.
  always_ff @(posedge s_clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (flush) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end
  end

  // Output mapping. The head word falls straight through from memory so
  // the next word is visible in the same cycle a pop happens.
  assign parallel_data_out = r_mem[r_rdPtr[AW-1:0]];
  assign out_valid         = !w_empty;
  assign empty             = w_empty;
  assign full              = w_full;
  assign grant             = !w_full;
  assign overrun           = r_overrun;
  assign bit_count         = r_bitCount;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_to_parallel_rx
//
// Directed bench for serial_to_parallel_rx with the default parameters
// (WIDTH=32, DEPTH=4, MSB_FIRST=1). Single-word transfers come from a table
// of records; reset, stalls, overflow, flush and the full-with-pop corner are
// hand-written sequences. Inputs change 1 time unit after the rising edge and
// outputs are checked at that same point, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_serial_to_parallel_rx;

  logic        s_clk;
  logic        rst;
  logic        flush;
  logic        serial_in;
  logic        serial_valid;
  logic        grant;
  logic [31:0] parallel_data_out;
  logic        out_valid;
  logic        out_ready;
  logic        full;
  logic        empty;
  logic        overrun;
  logic [4:0]  bit_count;

  int checkCount;
  int errorCount;

  typedef struct {
    logic [31:0] word;
    int          probeBits;
    logic [31:0] expCount;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs [6];

  serial_to_parallel_rx #(
    .WIDTH     (32),
    .DEPTH     (4),
    .MSB_FIRST (1'b1)
  ) dut (
    .s_clk             (s_clk),
    .rst               (rst),
    .flush             (flush),
    .serial_in         (serial_in),
    .serial_valid      (serial_valid),
    .grant             (grant),
    .parallel_data_out (parallel_data_out),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .full              (full),
    .empty             (empty),
    .overrun           (overrun),
    .bit_count         (bit_count)
  );

  // Free-running 10-unit clock.
  initial begin
    s_clk = 1'b0;
    forever #5 s_clk = ~s_clk;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge s_clk);
    #1;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Send bits firstBit..lastBit (ordinal, 0 = first on the wire) of word,
  // MSB first, back to back, then drop serial_valid.
  task automatic applyStimulus(input logic [31:0] word, input int firstBit,
                               input int lastBit);
    for (int k = firstBit; k <= lastBit; k++) begin
      serial_in    = word[31-k];
      serial_valid = 1'b1;
      tick();
    end
    serial_valid = 1'b0;
    serial_in    = 1'b0;
  endtask

  // Take the head word with a one-cycle ready pulse.
  task automatic popWord();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    checkCount   = 0;
    errorCount   = 0;
    rst          = 1'b1;
    flush        = 1'b0;
    serial_in    = 1'b0;
    serial_valid = 1'b0;
    out_ready    = 1'b0;

    vecs[0] = '{word: 32'h0000_0001, probeBits: 31, expCount: 32'd31, expData: 32'h0000_0001};
    vecs[1] = '{word: 32'h8000_0000, probeBits: 1,  expCount: 32'd1,  expData: 32'h8000_0000};
    vecs[2] = '{word: 32'hAAAA_AAAA, probeBits: 16, expCount: 32'd16, expData: 32'hAAAA_AAAA};
    vecs[3] = '{word: 32'h5555_5555, probeBits: 7,  expCount: 32'd7,  expData: 32'h5555_5555};
    vecs[4] = '{word: 32'hFFFF_FFFF, probeBits: 30, expCount: 32'd30, expData: 32'hFFFF_FFFF};
    vecs[5] = '{word: 32'h0000_0000, probeBits: 12, expCount: 32'd12, expData: 32'h0000_0000};

    // Reset held for three edges with valid ones on the wire.
    serial_valid = 1'b1;
    serial_in    = 1'b1;
    repeat (3) tick();
    checkOutput("rst_bit_count", bit_count, 0);
    checkOutput("rst_empty",     empty,     1);
    checkOutput("rst_full",      full,      0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_grant",     grant,     1);
    checkOutput("rst_overrun",   overrun,   0);
    rst          = 1'b0;
    serial_valid = 1'b0;
    serial_in    = 1'b0;
    tick();
    checkOutput("post_rst_empty", empty, 1);

    // Single word, latency of exactly one cycle after the last bit.
    applyStimulus(32'h1111_1111, 0, 30);
    checkOutput("single_before_last_valid", out_valid, 0);
    checkOutput("single_before_last_count", bit_count, 31);
    applyStimulus(32'h1111_1111, 31, 31);
    checkOutput("single_out_valid", out_valid, 1);
    checkOutput("single_data",      parallel_data_out, 32'h1111_1111);
    checkOutput("single_empty",     empty, 0);
    checkOutput("single_count",     bit_count, 0);
    tick();
    checkOutput("single_hold_valid", out_valid, 1);
    popWord();
    checkOutput("single_pop_empty", empty, 1);

    // Pop while empty must be ignored.
    popWord();
    checkOutput("empty_pop_empty", empty, 1);
    checkOutput("empty_pop_full",  full,  0);

    // Table-driven single-word transfers with a mid-word count probe.
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].word, 0, vecs[v].probeBits - 1);
      checkOutput($sformatf("vec%0d_count", v), bit_count, vecs[v].expCount);
      applyStimulus(vecs[v].word, vecs[v].probeBits, 31);
      checkOutput($sformatf("vec%0d_valid", v), out_valid, 1);
      checkOutput($sformatf("vec%0d_data", v), parallel_data_out, vecs[v].expData);
      popWord();
      checkOutput($sformatf("vec%0d_drained", v), empty, 1);
    end

    // Stalls of three cycles after ordinal bits 5 and 20.
    applyStimulus(32'hFFFF_0000, 0, 5);
    repeat (3) begin
      tick();
      checkOutput("stall1_count", bit_count, 6);
    end
    applyStimulus(32'hFFFF_0000, 6, 20);
    repeat (3) begin
      tick();
      checkOutput("stall2_count", bit_count, 21);
    end
    checkOutput("stall_not_valid", out_valid, 0);
    applyStimulus(32'hFFFF_0000, 21, 31);
    checkOutput("stall_data",  parallel_data_out, 32'hFFFF_0000);
    checkOutput("stall_valid", out_valid, 1);
    popWord();

    // Overflow: four words fill the FIFO, the fifth is dropped.
    for (int w = 1; w <= 4; w++) begin
      applyStimulus(32'hA000_0000 + 32'(w), 0, 31);
      if (w == 3) begin
        checkOutput("ovf_three_full", full, 0);
      end
    end
    checkOutput("ovf_full",  full,  1);
    checkOutput("ovf_grant", grant, 0);
    checkOutput("ovf_no_overrun_yet", overrun, 0);
    applyStimulus(32'hDEAD_BEEF, 0, 31);
    checkOutput("ovf_overrun", overrun, 1);
    checkOutput("ovf_still_full", full, 1);
    checkOutput("ovf_count_restart", bit_count, 0);
    for (int w = 1; w <= 4; w++) begin
      checkOutput($sformatf("ovf_drain%0d", w), parallel_data_out, 32'hA000_0000 + 32'(w));
      popWord();
    end
    checkOutput("ovf_drained_empty", empty, 1);
    checkOutput("ovf_sticky", overrun, 1);

    // Flush with two buffered words and ten partial bits.
    applyStimulus(32'h0BAD_0001, 0, 31);
    applyStimulus(32'h0BAD_0002, 0, 31);
    applyStimulus(32'hFFFF_FFFF, 0, 9);
    checkOutput("flush_pre_count", bit_count, 10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_count",   bit_count, 0);
    checkOutput("flush_empty",   empty, 1);
    checkOutput("flush_overrun", overrun, 0);
    checkOutput("flush_grant",   grant, 1);
    applyStimulus(32'h1234_5678, 0, 31);
    checkOutput("flush_clean_data", parallel_data_out, 32'h1234_5678);
    popWord();
    checkOutput("flush_clean_empty", empty, 1);

    // Full FIFO with a pop on the same edge as the final bit of a push.
    for (int w = 1; w <= 4; w++) begin
      applyStimulus(32'hB000_0000 + 32'(w), 0, 31);
    end
    checkOutput("fp_full", full, 1);
    applyStimulus(32'hCAFE_F00D, 0, 30);
    out_ready = 1'b1;
    applyStimulus(32'hCAFE_F00D, 31, 31);
    out_ready = 1'b0;
    checkOutput("fp_overrun", overrun, 0);
    checkOutput("fp_full_kept", full, 1);
    checkOutput("fp_head", parallel_data_out, 32'hB000_0002);
    for (int w = 2; w <= 4; w++) begin
      checkOutput($sformatf("fp_drain%0d", w), parallel_data_out, 32'hB000_0000 + 32'(w));
      popWord();
    end
    checkOutput("fp_last_word", parallel_data_out, 32'hCAFE_F00D);
    popWord();
    checkOutput("fp_final_empty", empty, 1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
